decoder_scan: RTL and testbench
===============================

# decoder_scan

Scan sequencer that drives the select (`A[2:0]`) and enable (`E`) inputs of the team's 3-to-8 `decoder`. It steps through channels 0..`last`, holding each channel enabled for a fixed dwell time with an optional disabled gap between channels, so the decoder's one-hot output can multiplex 8 LEDs or digits. Both single-pass and continuous scanning are supported. It sits directly upstream of `decoder`: `A` and `E` connect 1:1 to the decoder's `A` and `E`.

## Interface
- `DWELL`, default 4: number of cycles each channel is held with `E`=1. Legal range is ≥1.
- `BLANK`, default 1: number of cycles with `E`=0 between channels. Legal range is ≥0; 0 means no gap.
- `clk`  in  1  clock; all logic is on its rising edge.
- `rst`  in  1  **synchronous, active-high** reset.
- `start`  in  1  begins a scan. Sampled only in IDLE.
- `stop`  in  1  aborts a scan immediately. Has priority over `start`.
- `mode`  in  1  0 = continuous, 1 = single pass. Latched on `start`.
- `last`  in  3  highest channel index to scan (0..7). Latched on `start`.
- `A`  out  3  channel select to the decoder. Registered.
- `E`  out  1  enable to the decoder. Registered.
- `busy`  out  1  high in ACTIVE and GAP.
- `done`  out  1  one-cycle pulse at the end of a single pass.

## Operation
- States are IDLE, ACTIVE and GAP. A dwell/gap counter is sized to hold max(`DWELL`, `BLANK`).
- **Reset:** state = IDLE, `A`=0, `E`=0, `busy`=0, `done`=0, counter = 0, latched `mode`/`last` = 0. Reset applies mid-scan in the same way, with no `done` pulse.
- **IDLE:** `A`=0, `E`=0.
  - `start`=1 and `stop`=0 → ACTIVE with `A`=0 and counter = 0. `mode` and `last` are latched at this point.
- **ACTIVE:** `E`=1 for exactly `DWELL` cycles. At the end of the dwell:
  - If `A` ≠ latched `last`: `A` ← `A`+1. Go to GAP if `BLANK`>0, otherwise stay in ACTIVE.
  - If `A` = latched `last` and mode = single: go to IDLE (`A`=0, `E`=0) with `done`=1 for one cycle. There is no trailing gap.
  - If `A` = latched `last` and mode = continuous: `A` wraps to 0. Go to GAP if `BLANK`>0, otherwise stay in ACTIVE.
- **GAP:** `E`=0 for exactly `BLANK` cycles while `A` already holds the next channel, so the select settles while the decoder is disabled. Then go to ACTIVE.
- `stop`=1 in ACTIVE or GAP → next cycle IDLE, `A`=0, `E`=0, no `done`.
- `start` while busy is ignored.
- `start` and `stop` in the same cycle in IDLE → remain in IDLE.
- Changes to `mode` or `last` while busy are ignored until the next `start`.
- `last`=0 means only channel 0 is scanned:
  - single mode: one dwell, then `done`.
  - continuous mode: dwell/gap alternating on channel 0.
- `E` is never 1 while `A` is changing: `A` changes only on a transition into GAP, or directly dwell-to-dwell when `BLANK`=0.

## Timing
- Cycle *n* is the rising edge at which `start` is sampled. `A` and `E` reflect ACTIVE from cycle *n*+1, giving a latency of 1 cycle.
- In single mode, `busy`=1 for (`last`+1)·`DWELL` + `last`·`BLANK` cycles. `done` is asserted in the first cycle after that, with `busy`=0.
- In continuous mode the period is (`last`+1)·(`DWELL`+`BLANK`) cycles.
- `stop` or `rst` sampled at cycle *m* → `E`=0, `A`=0, `busy`=0 from cycle *m*+1.
- `done` is never asserted on abort, on reset, or in continuous mode.

## Test plan
- **Reset:** hold `rst` 2 cycles with `start`=1 → `A`=0, `E`=0, `busy`=0, `done`=0 throughout and in the first cycle after release.
- **Single pass:** `DWELL`=4, `BLANK`=1, `last`=1, `mode`=1, `start` at cycle 0 →
  - cycles 1–4: `A`=0, `E`=1
  - cycle 5: `A`=1, `E`=0
  - cycles 6–9: `A`=1, `E`=1
  - cycle 10: `A`=0, `E`=0, `done`=1, `busy`=0
  - cycle 11: `done`=0
- **Continuous wrap:** `last`=7, `mode`=0, `BLANK`=0, `DWELL`=2 → `A` steps 0,0,1,1,…,7,7,0,0 with `E` constantly 1. The period is 16 cycles. Check that the `decoder` output `D` walks 01h→80h→01h.
- **Abort:** in continuous mode, assert `stop` during a GAP with `A`=3 → next cycle IDLE, `A`=0, `E`=0, `done` never pulses.
- **Ignored inputs:** while busy, pulse `start` and change `last` from 2 to 5 → the sequence is unchanged and ends after channel 2. `start`+`stop` together in IDLE → stays in IDLE.
- **Edge configuration:** `last`=0, `mode`=1, `DWELL`=1, `BLANK`=3 → cycle 1: `A`=0, `E`=1; cycle 2: `done`=1. There is no gap.

Source files
------------

// File: rtl/decoder_scan.sv
// Scan sequencer driving the select/enable pins of the 3-to-8 decoder.
// Walks channels 0..last with a fixed dwell per channel and an optional blank gap.
module decoder_scan #(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_mode,
    input  logic [2:0] i_last,
    output logic [2:0] o_a,
    output logic       o_e,
    output logic       o_busy,
    output logic       o_done
);

    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (MAXC <= 2) ? 1 : $clog2(MAXC);

    localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_END = (BLANK > 0) ? CW'(BLANK - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_mode;
    logic [2:0]      r_last;
    logic [2:0]      r_a;
    logic            r_e;
    logic            r_busy;
    logic            r_done;

    logic            w_dwellEnd;
    logic            w_gapEnd;
    logic            w_lastChan;

    assign w_dwellEnd = (r_cnt == DWELL_END);
    assign w_gapEnd   = (r_cnt == BLANK_END);
    assign w_lastChan = (r_a == r_last);

    // Select only moves on the edge that also drops enable (or dwell-to-dwell when BLANK is 0).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_last  <= 3'd0;
            r_a     <= 3'd0;
            r_e     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_a    <= 3'd0;
                    r_e    <= 1'b0;
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                    if (i_start && !i_stop) begin
                        r_state <= S_ACTIVE;
                        r_e     <= 1'b1;
                        r_busy  <= 1'b1;
                        r_mode  <= i_mode;
                        r_last  <= i_last;
                    end
                end
                S_ACTIVE: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                        r_a     <= 3'd0;
                        r_e     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (!w_dwellEnd) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= '0;
                        if (w_lastChan && r_mode) begin
                            r_state <= S_IDLE;
                            r_a     <= 3'd0;
                            r_e     <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_a <= w_lastChan ? 3'd0 : r_a + 3'd1;
                            if (BLANK > 0) begin
                                r_state <= S_GAP;
                                r_e     <= 1'b0;
                            end else begin
                                r_e <= 1'b1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                        r_a     <= 3'd0;
                        r_e     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (!w_gapEnd) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_state <= S_ACTIVE;
                        r_e     <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_a     <= 3'd0;
                    r_e     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_a    = r_a;
    assign o_e    = r_e;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: three instances cover the DWELL/BLANK configurations exercised.
module tb_decoder_scan;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [2:0] last;

    logic [2:0] aSel, bSel, cSel;
    logic       aEn, bEn, cEn;
    logic       aBusy, bBusy, cBusy;
    logic       aDone, bDone, cDone;

    int errors = 0;
    int checks = 0;

    decoder_scan #(.DWELL(4), .BLANK(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode), .i_last(last),
        .o_a(aSel), .o_e(aEn), .o_busy(aBusy), .o_done(aDone));

    decoder_scan #(.DWELL(2), .BLANK(0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode), .i_last(last),
        .o_a(bSel), .o_e(bEn), .o_busy(bBusy), .o_done(bDone));

    decoder_scan #(.DWELL(1), .BLANK(3)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode), .i_last(last),
        .o_a(cSel), .o_e(cEn), .o_busy(cBusy), .o_done(cDone));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each tick lands 1ns after a rising edge, so the value seen is "cycle k" for the k-th edge after start.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        stop  = 1'b0;
        mode  = 1'b1;
        last  = 3'd3;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({aSel, aEn, aBusy, aDone} !== 6'b000000) begin
                errors++;
                $display("[TB] FAIL reset_hold%0d: got %b want %b", k, {aSel, aEn, aBusy, aDone}, 6'b000000);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if ({aSel, aEn, aBusy, aDone} !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b want %b", {aSel, aEn, aBusy, aDone}, 6'b000000);
        end
    endtask

    task automatic test_single_pass();
        pulse_reset();
        mode  = 1'b1;
        last  = 3'd1;
        start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            logic [5:0] expV;
            tick();
            start = 1'b0;
            if (k <= 4)       expV = {3'd0, 1'b1, 1'b1, 1'b0};
            else if (k == 5)  expV = {3'd1, 1'b0, 1'b1, 1'b0};
            else if (k <= 9)  expV = {3'd1, 1'b1, 1'b1, 1'b0};
            else if (k == 10) expV = {3'd0, 1'b0, 1'b0, 1'b1};
            else              expV = {3'd0, 1'b0, 1'b0, 1'b0};
            checks++;
            if ({aSel, aEn, aBusy, aDone} !== expV) begin
                errors++;
                $display("[TB] FAIL single_c%0d: got %b want %b", k, {aSel, aEn, aBusy, aDone}, expV);
            end
        end
    endtask

    task automatic test_continuous_wrap();
        logic [7:0] decD;
        logic [7:0] expD;
        logic [2:0] expA;
        pulse_reset();
        mode  = 1'b0;
        last  = 3'd7;
        start = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            start = 1'b0;
            expA = 3'((k - 1) / 2);
            expD = 8'h01 << expA;
            decD = bEn ? (8'h01 << bSel) : 8'h00;
            checks++;
            if ({bSel, bEn, bBusy, bDone} !== {expA, 1'b1, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL wrap_c%0d: got %b want %b", k, {bSel, bEn, bBusy, bDone}, {expA, 3'b110});
            end
            checks++;
            if (decD !== expD) begin
                errors++;
                $display("[TB] FAIL wrap_D_c%0d: got %h want %h", k, decD, expD);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({bSel, bEn, bBusy, bDone} !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL wrap_stop: got %b want %b", {bSel, bEn, bBusy, bDone}, 6'b000000);
        end
    endtask

    task automatic test_abort();
        int doneSeen;
        doneSeen = 0;
        pulse_reset();
        mode  = 1'b0;
        last  = 3'd7;
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            start = 1'b0;
            if (aDone === 1'b1) doneSeen++;
        end
        checks++;
        if ({aSel, aEn, aBusy} !== {3'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL abort_gap: got %b want %b", {aSel, aEn, aBusy}, {3'd3, 2'b01});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        if (aDone === 1'b1) doneSeen++;
        checks++;
        if ({aSel, aEn, aBusy, aDone} !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL abort_next: got %b want %b", {aSel, aEn, aBusy, aDone}, 6'b000000);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (aDone === 1'b1) doneSeen++;
        end
        checks++;
        if (aBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: busy got %b want 0", aBusy);
        end
        checks++;
        if (doneSeen !== 0) begin
            errors++;
            $display("[TB] FAIL abort_done: pulses got %0d want 0", doneSeen);
        end
    endtask

    task automatic test_ignored_inputs();
        pulse_reset();
        mode  = 1'b1;
        last  = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        last  = 3'd5;
        mode  = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 4; k <= 10; k++) tick();
        checks++;
        if ({aSel, aEn, aBusy} !== {3'd2, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL ignore_gap2: got %b want %b", {aSel, aEn, aBusy}, {3'd2, 2'b01});
        end
        for (int k = 11; k <= 14; k++) tick();
        checks++;
        if ({aSel, aEn, aBusy, aDone} !== {3'd2, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL ignore_last: got %b want %b", {aSel, aEn, aBusy, aDone}, {3'd2, 3'b110});
        end
        tick();
        checks++;
        if ({aSel, aEn, aBusy, aDone} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL ignore_done: got %b want %b", {aSel, aEn, aBusy, aDone}, {3'd0, 3'b001});
        end
        tick();
        checks++;
        if ({aSel, aEn, aBusy, aDone} !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL ignore_after: got %b want %b", {aSel, aEn, aBusy, aDone}, 6'b000000);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if ({aSel, aEn, aBusy, aDone} !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL start_stop_idle: got %b want %b", {aSel, aEn, aBusy, aDone}, 6'b000000);
        end
    endtask

    task automatic test_edge_config();
        pulse_reset();
        mode  = 1'b1;
        last  = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({cSel, cEn, cBusy, cDone} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL edge_c1: got %b want %b", {cSel, cEn, cBusy, cDone}, {3'd0, 3'b110});
        end
        tick();
        checks++;
        if ({cSel, cEn, cBusy, cDone} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL edge_c2: got %b want %b", {cSel, cEn, cBusy, cDone}, {3'd0, 3'b001});
        end
        tick();
        checks++;
        if ({cSel, cEn, cBusy, cDone} !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL edge_c3: got %b want %b", {cSel, cEn, cBusy, cDone}, 6'b000000);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        last  = 3'd0;
        test_reset();
        test_single_pass();
        test_continuous_wrap();
        test_abort();
        test_ignored_inputs();
        test_edge_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
